scrambler_descrambler: RTL and testbench

- Parametrised successor to the combinational 8-bit encode/decode loopback.
- Stage 1 scrambles each input word with an LFSR keystream, the way the transmitter does.
- Stage 2 descrambles it with an identical, lock-stepped receiver LFSR, so data_out equals data_in two stages later.
- Valid/ready handshakes, backpressure and a resync command. The scrambled word is exported for line-side monitoring.

---
 rtl/scr_pkg.sv | 34 +++
 rtl/scr_lfsr_stage.sv | 76 +++++++
 rtl/scrambler_descrambler.sv | 99 +++++++++
 tb/tb_scrambler_descrambler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scr_pkg.sv
// Shared constants and the Galois LFSR keystream helper used by both the
// scrambling (tx) and descrambling (rx) stages.
package scr_pkg;

    localparam int LFSR_MAX_W = 32;
    localparam int DATA_MAX_W = 64;

    localparam logic [15:0] SCR_SEED_DEF = 16'hACE1;
    localparam logic [15:0] SCR_TAPS_DEF = 16'hB400;

    typedef struct packed {
        logic [DATA_MAX_W-1:0] ks;
        logic [LFSR_MAX_W-1:0] state;
    } lfsr_step_t;

    // Keystream bit i is lfsr[0] before step i; the state is returned after n steps.
    function automatic lfsr_step_t lfsr_step_n(input logic [LFSR_MAX_W-1:0] state,
                                               input int                    n,
                                               input logic [LFSR_MAX_W-1:0] taps);
        lfsr_step_t            r;
        logic [LFSR_MAX_W-1:0] s;
        s    = state;
        r.ks = '0;
        for (int i = 0; i < DATA_MAX_W; i++) begin
            if (i < n) begin
                r.ks[i] = s[0];
                s       = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
            end
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/scr_lfsr_stage.sv
// One pipeline register stage holding a word, its bypass flag and a private
// LFSR; a load XORs the incoming word with the next DATA_W keystream bits.
module scr_lfsr_stage
    import scr_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              byp_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              byp_o
);

    localparam logic [LFSR_MAX_W-1:0] TAPS_X = LFSR_MAX_W'(TAPS);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              byp_q, byp_d;
    lfsr_step_t        step;
    logic              unused_step;

    assign step        = lfsr_step_n(LFSR_MAX_W'(lfsr_q), DATA_W, TAPS_X);
    assign unused_step = ^step;

    always_comb begin
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        valid_d = valid_q;
        byp_d   = byp_q;
        if (flush_i) begin
            valid_d = 1'b0;
            lfsr_d  = SEED;
        end else if (load_i) begin
            valid_d = 1'b1;
            byp_d   = byp_i;
            // A bypassed word passes in clear and leaves the keystream untouched.
            if (byp_i) begin
                data_d = data_i;
            end else begin
                data_d = data_i ^ step.ks[DATA_W-1:0];
                lfsr_d = step.state[LFSR_W-1:0];
            end
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            byp_q   <= byp_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign byp_o   = byp_q;

endmodule

// File: rtl/scrambler_descrambler.sv
// Two-stage scramble/descramble loopback with valid/ready flow control and resync.
// Optional macro SCR_BYPASS_EN adds a per-word bypass input.
module scrambler_descrambler
    import scr_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = SCR_SEED_DEF,
    parameter logic [LFSR_W-1:0] TAPS   = SCR_TAPS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
`ifdef SCR_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              resync,
    output logic              scr_valid,
    output logic [DATA_W-1:0] scr_mon,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
);

    logic [1:0] rst_sync_q;
    logic       rst_done;
    logic       s1_valid, s2_valid;
    logic       s1_byp, s2_byp;
    logic       s1_free, s2_free;
    logic       s1_load, s12_xfer, s2_pop;
    logic       in_byp;
    logic       unused_s2_byp;

`ifdef SCR_BYPASS_EN
    assign in_byp = bypass;
`else
    assign in_byp = 1'b0;
`endif

    // Reset asserts asynchronously but input acceptance only resumes two edges after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_done = rst_sync_q[1];

    assign s2_free  = !s2_valid || out_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = s1_free && !resync && rst_done;
    assign s1_load  = in_valid && in_ready;
    assign s12_xfer = s1_valid && s2_free && !resync;
    assign s2_pop   = s2_valid && out_ready;

    scr_lfsr_stage #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (TAPS)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (resync),
        .load_i  (s1_load),
        .pop_i   (s12_xfer),
        .data_i  (data_in),
        .byp_i   (in_byp),
        .valid_o (s1_valid),
        .data_o  (scr_mon),
        .byp_o   (s1_byp)
    );

    scr_lfsr_stage #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (TAPS)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (resync),
        .load_i  (s12_xfer),
        .pop_i   (s2_pop),
        .data_i  (scr_mon),
        .byp_i   (s1_byp),
        .valid_o (s2_valid),
        .data_o  (data_out),
        .byp_o   (s2_byp)
    );

    assign unused_s2_byp = s2_byp;
    assign scr_valid     = s1_valid;
    assign out_valid     = s2_valid;

endmodule

// File: tb/tb_scrambler_descrambler.sv
// Directed bench for scrambler_descrambler; build with SCR_BYPASS_EN to
// also exercise the bypass path.
module tb_scrambler_descrambler;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic       resync;
    logic       scr_valid;
    logic [7:0] scr_mon;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
`ifdef SCR_BYPASS_EN
    logic       bypass;
`endif

    int checks;
    int failures;

    scrambler_descrambler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
`ifdef SCR_BYPASS_EN
        .bypass    (bypass),
`endif
        .resync    (resync),
        .scr_valid (scr_valid),
        .scr_mon   (scr_mon),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_resync();
        in_valid = 1'b0;
        resync   = 1'b1;
        tick();
        resync   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 8'h00;
        resync    = 1'b0;
        out_ready = 1'b1;
`ifdef SCR_BYPASS_EN
        bypass    = 1'b0;
`endif
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL reset_scr_valid got=%b exp=0", scr_valid); end
        checks++; if (scr_mon !== 8'h00) begin failures++; $display("FAIL reset_scr_mon got=%h exp=00", scr_mon); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        data_in   = 8'h5B;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        checks++; if (scr_valid !== 1'b1) begin failures++; $display("FAIL single_scr_valid got=%b exp=1", scr_valid); end
        checks++; if (scr_mon !== 8'hBA) begin failures++; $display("FAIL single_scr_mon got=%h exp=ba", scr_mon); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_out_valid_early got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (data_out !== 8'h5B) begin failures++; $display("FAIL single_data_out got=%h exp=5b", data_out); end
        checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL single_scr_drain got=%b exp=0", scr_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_out_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        resync = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_resync_in_ready got=%b exp=0", in_ready); end
        tick();
        resync   = 1'b0;
        out_ready = 1'b1;
        data_in  = 8'h5B;
        in_valid = 1'b1;
        tick();
        data_in  = 8'h73;
        checks++; if (scr_mon !== 8'hBA) begin failures++; $display("FAIL b2b_scr_mon0 got=%h exp=ba", scr_mon); end
        tick();
        in_valid = 1'b0;
        checks++; if (scr_mon !== 8'hB7) begin failures++; $display("FAIL b2b_scr_mon1 got=%h exp=b7", scr_mon); end
        checks++; if (out_valid !== 1'b1 || data_out !== 8'h5B) begin failures++; $display("FAIL b2b_out0 got=%b/%h exp=1/5b", out_valid, data_out); end
        tick();
        checks++; if (out_valid !== 1'b1 || data_out !== 8'h73) begin failures++; $display("FAIL b2b_out1 got=%b/%h exp=1/73", out_valid, data_out); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] w [6];
        int  sent;
        int  got;
        logic acc;
        w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        sent = 0;
        got  = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            data_in  = w[sent];
            in_valid = 1'b1;
            #1;
            acc = in_ready;
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1 || data_out !== 8'hA0) begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/a0", c, out_valid, data_out); end
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        checks++; if (sent !== 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", sent); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            data_in  = (sent < 6) ? w[sent] : 8'h00;
            in_valid = (sent < 6);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                checks++; if (data_out !== w[got]) begin failures++; $display("FAIL stall_order idx=%0d got=%h exp=%h", got, data_out, w[got]); end
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", got); end
        tick();
    endtask

    task automatic test_resync();
        do_resync();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h11;
        tick();
        data_in   = 8'h22;
        tick();
        checks++; if (scr_valid !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL resync_full got=%b/%b exp=1/1", scr_valid, out_valid); end
        resync    = 1'b1;
        out_ready = 1'b1;
        data_in   = 8'h33;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL resync_in_ready got=%b exp=0", in_ready); end
        tick();
        resync   = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL resync_out_valid got=%b exp=0", out_valid); end
        checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL resync_scr_valid got=%b exp=0", scr_valid); end
        data_in  = 8'h5B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (scr_mon !== 8'hBA) begin failures++; $display("FAIL resync_reseed got=%h exp=ba", scr_mon); end
        tick();
        checks++; if (data_out !== 8'h5B) begin failures++; $display("FAIL resync_data_out got=%h exp=5b", data_out); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 8'h44;
        tick();
        data_in   = 8'h55;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
        checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL arst_scr_valid got=%b exp=0", scr_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        data_in  = 8'h73;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (scr_mon !== 8'h92) begin failures++; $display("FAIL arst_scr_mon got=%h exp=92", scr_mon); end
        tick();
        checks++; if (out_valid !== 1'b1 || data_out !== 8'h73) begin failures++; $display("FAIL arst_data_out got=%b/%h exp=1/73", out_valid, data_out); end
        tick();
    endtask

`ifdef SCR_BYPASS_EN
    task automatic test_bypass();
        do_resync();
        out_ready = 1'b1;
        data_in   = 8'h5B;
        bypass    = 1'b1;
        in_valid  = 1'b1;
        tick();
        bypass    = 1'b0;
        checks++; if (scr_mon !== 8'h5B) begin failures++; $display("FAIL byp_scr_mon0 got=%h exp=5b", scr_mon); end
        tick();
        in_valid  = 1'b0;
        checks++; if (scr_mon !== 8'hBA) begin failures++; $display("FAIL byp_scr_mon1 got=%h exp=ba", scr_mon); end
        checks++; if (data_out !== 8'h5B) begin failures++; $display("FAIL byp_data_out0 got=%h exp=5b", data_out); end
        tick();
        checks++; if (out_valid !== 1'b1 || data_out !== 8'h5B) begin failures++; $display("FAIL byp_data_out1 got=%b/%h exp=1/5b", out_valid, data_out); end
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_async_reset();
`ifdef SCR_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
